// File: rtl/multiply_accumulate.sv
// multiply_accumulate
//
// Streaming fixed-point dot-product stage. It accepts ARGN signed operand
// pairs {weight, input}, one per handshake. Each product is scaled down by
// FRAC bits and summed into a RESW-bit wrapping accumulator. The sum is then
// presented as a single result beat, which the following saturate stage
// narrows to the datapath width.
//
// Ports
//   clk        in   1        clock
//   rst        in   1        synchronous reset, active-high
//   arg_valid  in   1        operand pair valid
//   arg_data   in   2*ARGW   {weight, input}, both signed
//   arg_ready  out  1        stage accepts a pair this cycle
//   res_valid  out  1        result valid
//   res_data   out  RESW     accumulated sum, signed
//   res_ready  in   1        downstream accepts result
//   dbg_state  out  1        current FSM state (0 = ACC, 1 = RES)
//
// Handshake: a beat moves on a rising clk edge where valid and ready are
// both high. A producer holds valid and data stable until that edge. Ready
// may depend on state only, and never depends on the opposite valid.

module multiply_accumulate #(
    parameter int ARGW = 16,
    parameter int ARGN = 4,
    parameter int RESW = 24,
    parameter int FRAC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arg_valid,
    input  logic [2*ARGW-1:0] arg_data,
    output logic              arg_ready,
    output logic              res_valid,
    output logic [RESW-1:0]   res_data,
    input  logic              res_ready,
    output logic              dbg_state
);

    localparam int CNTW = (ARGN > 1) ? $clog2(ARGN) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ARGN - 1);

    typedef enum logic {
        S_ACC = 1'b0,
        S_RES = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [RESW-1:0]    acc_q, acc_d;

    logic signed [ARGW-1:0]   weight;
    logic signed [ARGW-1:0]   operand;
    logic signed [2*ARGW-1:0] prod;
    logic signed [2*ARGW-1:0] prod_shr;
    logic [RESW-1:0]          prod_res;

    logic arg_xfer;
    logic res_xfer;

    assign weight  = $signed(arg_data[2*ARGW-1:ARGW]);
    assign operand = $signed(arg_data[ARGW-1:0]);

    // The full-width product is formed first. The arithmetic shift then
    // rounds toward -inf. The size cast sign-extends or truncates the result
    // to the accumulator width.
    assign prod     = weight * operand;
    assign prod_shr = prod >>> FRAC;
    assign prod_res = RESW'(prod_shr);

    // Both ready/valid outputs are also gated by rst. This keeps the stage
    // closed and silent in the same cycle that reset is asserted.
    assign arg_ready = (state_q == S_ACC) && !rst;
    assign res_valid = (state_q == S_RES) && !rst;
    assign res_data  = acc_q;
    assign dbg_state = state_q;

    assign arg_xfer = arg_valid && arg_ready;
    assign res_xfer = res_valid && res_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        unique case (state_q)
            S_ACC: begin
                if (arg_xfer) begin
                    // The first pair of a group overwrites the previous sum.
                    // This means RES never needs to clear the accumulator.
                    acc_d = ((cnt_q == '0) ? '0 : acc_q) + prod_res;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_RES;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RES: begin
                if (res_xfer) begin
                    state_d = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

endmodule
